rlwe_decrypt_par: RTL and testbench
===================================

# rlwe_decrypt_par

Parametrised ring-LWE decryption core. It computes m = decode(c1 + c2·r2) over Z_Q[x]/(x^N+1), with Q = 2^LOG_Q and a binary polynomial r2. The core is the successor of the fixed 256×8-bit, one-bit-per-cycle decryptor: N, LOG_Q and the number of r2 bits consumed per cycle are generics, operands are captured on a start handshake, and the result is held until the consumer acknowledges it. It sits between the ciphertext buffer and the message sink in the decryption datapath.

## Interface
- N, default 256: polynomial degree (number of coefficients); N ≥ 2.
- LOG_Q, default 8: coefficient width in bits; modulus Q = 2^LOG_Q; LOG_Q ≥ 2.
- D, default 1: r2 bits consumed per multiply cycle; D ≥ 1, and D must divide N.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request to decrypt; accepted only while ready = 1.
- ready  out  1  core idle and able to accept start; combinational from state.
- r2  in  N  binary polynomial; bit i is the coefficient of x^i.
- c1  in  N·LOG_Q  ciphertext polynomial 1; coefficient i is c1[i·LOG_Q +: LOG_Q].
- c2  in  N·LOG_Q  ciphertext polynomial 2; same packing as c1.
- m  out  N  decoded message; bit i comes from coefficient i.
- valid  out  1  m is valid; held high until acknowledged.
- ack  in  1  consumer accepts m.

## Operation
- States:
  - IDLE: ready = 1.
  - MUL: N/D cycles.
  - ADD: 1 cycle.
  - DONE: valid = 1.
- IDLE → MUL on an edge with start = 1:
  - r2, c1 and c2 are captured into internal registers.
  - The accumulator acc (N × LOG_Q) is cleared.
  - The step counter is cleared.
- start while ready = 0 is ignored and has no side effects.
- Input changes after capture have no effect on the operation in progress.
- MUL, per cycle: apply D Horner steps, most-significant r2 bit first. Step with bit b:
  - acc' = acc·x (negacyclic): acc'[0] = −acc[N−1] mod Q; acc'[i] = acc[i−1] for i ≥ 1.
  - Then, if b = 1, acc'[i] += c2[i] mod Q for all i.
  - Cycle k (k = 0..N/D−1) consumes r2 bits N−1−kD down to N−D−kD.
- MUL → ADD when the counter reaches N/D−1.
- ADD:
  - m[i] ← decode((acc[i] + c1[i]) mod Q).
  - decode(v) = 1 iff Q/4 ≤ v < 3Q/4, i.e. v[LOG_Q−1] XOR v[LOG_Q−2].
  - Go to DONE.
- DONE: valid = 1. The edge with ack = 1 returns the core to IDLE and clears valid.
- m holds its last value after returning to IDLE, until the next ADD.
- Arithmetic rules:
  - All coefficient arithmetic wraps modulo 2^LOG_Q; carries are truncated.
  - Negation is the two's complement truncated to LOG_Q bits (−0 = 0).
- The counter is ceil(log2(N/D)) bits wide. When N/D = 1, it has width 1 and MUL lasts exactly one cycle.

## Timing
- Reset (rst = 0, asynchronous):
  - state = IDLE, so ready = 1.
  - valid = 0, m = 0.
  - acc, counter and captured operands = 0.
- Reset takes effect immediately in any state. Deassertion is synchronous to clk; the source releases it away from the clock edge.
- Reset mid-MUL or mid-DONE aborts the operation. No valid pulse is produced, and m reads 0.
- Latency: with start accepted at edge t:
  - valid is high after edge t + N/D + 1.
  - ready returns high after the first edge ≥ t + N/D + 2 with ack = 1.
- ack sampled while valid = 0 is ignored.
- ack held high continuously completes the transaction at the first DONE edge, so valid is high for exactly one cycle.
- Throughput: at most one operation per N/D + 3 cycles. ready is low in DONE, so there is a guaranteed one-cycle gap between ack and the next accepted start.

## Test plan
- N=8, LOG_Q=8, D=1:
  - Reset: values and abort.
    - rst low → ready=1, valid=0, m=0x00.
    - Pulse rst low during MUL cycle 3 → returns to IDLE, valid never rises.
    - Next start completes normally.
  - Constant c1, no product.
    - r2=0x00, all c1 coefficients 0x80, c2 random, start.
    - valid rises after 9 edges with m=0xFF. With c1 all 0x3F → m=0x00.
  - Identity product.
    - r2=0x01, c2 coefficient 0 = 0x40 and other coefficients 0, c1=0 → m=0x01.
    - The same with c2 coefficient 0 = 0xC0 → m=0x00, since the 3Q/4 boundary is exclusive.
  - Negacyclic wrap.
    - r2=0x80 (x^7), c2 coefficient 1 = 0x60 and others 0, c1=0.
    - acc[0] = −0x60 = 0xA0 → m=0x01.
  - Handshake.
    - Hold ack=0 for 5 cycles in DONE → valid and m stable, and a start pulse is ignored.
    - Raise ack → next cycle valid=0, ready=1, m unchanged.
    - A start in the following cycle is accepted.
- D variants: random r2, c1, c2 at N=8, D=1, 2, 4 and 8, plus N=16, LOG_Q=12, D=4.
  - Results match a software negacyclic reference bit-exactly.
  - valid rises N/D + 1 cycles after start.

Source files
------------

// File: rtl/rlwe_decrypt_par.sv
// Ring-LWE decryption core: m = decode(c1 + c2*r2) over Z_Q[x]/(x^N+1), Q = 2^LOG_Q, D r2 bits per cycle.
// Latency: valid rises N/D+1 edges after the accepted start edge (N/D MUL cycles, then one ADD cycle).
// Backpressure: result held with valid high until ack; ready stays low until then, so start is ignored.
module rlwe_decrypt_par #(
    parameter int N     = 256,
    parameter int LOG_Q = 8,
    parameter int D     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ready,
    input  logic [N-1:0]         r2,
    input  logic [N*LOG_Q-1:0]   c1,
    input  logic [N*LOG_Q-1:0]   c2,
    output logic [N-1:0]         m,
    output logic                 valid,
    input  logic                 ack
);
    localparam int STEPS = N / D;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [N-1:0]       r_r2;
    logic [N*LOG_Q-1:0] r_c1;
    logic [N*LOG_Q-1:0] r_c2;
    logic [N*LOG_Q-1:0] r_acc;
    logic [N-1:0]       r_m;

    logic [N*LOG_Q-1:0] w_acc_nxt;
    logic [LOG_Q-1:0]   w_top;
    logic [LOG_Q-1:0]   w_neg;
    logic [LOG_Q-1:0]   w_sum;
    logic [N-1:0]       w_m_nxt;

    assign ready = (r_state == S_IDLE);
    assign valid = (r_state == S_DONE);
    assign m     = r_m;

    // D Horner steps per cycle; r_r2 is shifted left each cycle so the next bits are always at the top.
    always_comb begin
        w_acc_nxt = r_acc;
        w_top     = '0;
        w_neg     = '0;
        for (int j = 0; j < D; j++) begin
            // multiply by x: coefficients move up one slot, the top one wraps to slot 0 negated
            w_top     = w_acc_nxt[N*LOG_Q-1 -: LOG_Q];
            w_neg     = ~w_top + LOG_Q'(1);
            w_acc_nxt = {w_acc_nxt[(N-1)*LOG_Q-1:0], w_neg};
            if (r_r2[N-1-j]) begin
                for (int i = 0; i < N; i++) begin
                    w_acc_nxt[i*LOG_Q +: LOG_Q] = w_acc_nxt[i*LOG_Q +: LOG_Q] + r_c2[i*LOG_Q +: LOG_Q];
                end
            end
        end
    end

    // Final add of c1 and threshold decode: bit is 1 when Q/4 <= v < 3Q/4.
    always_comb begin
        w_m_nxt = '0;
        w_sum   = '0;
        for (int i = 0; i < N; i++) begin
            w_sum      = r_acc[i*LOG_Q +: LOG_Q] + r_c1[i*LOG_Q +: LOG_Q];
            w_m_nxt[i] = w_sum[LOG_Q-1] ^ w_sum[LOG_Q-2];
        end
    end

    // Control FSM plus operand capture, accumulator update and result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_r2    <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_acc   <= '0;
            r_m     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_r2    <= r2;
                        r_c1    <= c1;
                        r_c2    <= c2;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_nxt;
                    r_r2  <= r_r2 << D;
                    if (r_cnt == CW'(STEPS - 1)) begin
                        r_state <= S_ADD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_ADD: begin
                    r_m     <= w_m_nxt;
                    r_state <= S_DONE;
                end
                default: begin
                    if (ack) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rlwe_decrypt_par.sv
module tb_rlwe_decrypt_par;
    logic clk;
    logic rst;
    logic [4:0] start;
    logic [4:0] ack;
    logic [4:0] ready;
    logic [4:0] valid;

    logic [7:0]   r2a;
    logic [63:0]  c1a;
    logic [63:0]  c2a;
    logic [15:0]  r2b;
    logic [191:0] c1b;
    logic [191:0] c2b;

    logic [7:0]  m_d1, m_d2, m_d4, m_d8;
    logic [15:0] m_w;

    int n_checks;
    int n_fail;

    rlwe_decrypt_par #(.N(8), .LOG_Q(8), .D(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start[0]), .ready(ready[0]), .r2(r2a), .c1(c1a), .c2(c2a),
        .m(m_d1), .valid(valid[0]), .ack(ack[0]));
    rlwe_decrypt_par #(.N(8), .LOG_Q(8), .D(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start[1]), .ready(ready[1]), .r2(r2a), .c1(c1a), .c2(c2a),
        .m(m_d2), .valid(valid[1]), .ack(ack[1]));
    rlwe_decrypt_par #(.N(8), .LOG_Q(8), .D(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start[2]), .ready(ready[2]), .r2(r2a), .c1(c1a), .c2(c2a),
        .m(m_d4), .valid(valid[2]), .ack(ack[2]));
    rlwe_decrypt_par #(.N(8), .LOG_Q(8), .D(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start[3]), .ready(ready[3]), .r2(r2a), .c1(c1a), .c2(c2a),
        .m(m_d8), .valid(valid[3]), .ack(ack[3]));
    rlwe_decrypt_par #(.N(16), .LOG_Q(12), .D(4)) u_w (
        .clk(clk), .rst(rst), .start(start[4]), .ready(ready[4]), .r2(r2b), .c1(c1b), .c2(c2b),
        .m(m_w), .valid(valid[4]), .ack(ack[4]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  r2;
        logic [63:0] c1;
        logic [63:0] c2;
        logic [7:0]  exp_m;
    } vec_t;

    vec_t tv[6];
    int   lat_arr[5];
    int   nv_arr[5];
    logic [15:0] got_arr[5];
    logic [15:0] exp_arr[5];
    int   exp_lat[5] = '{9, 5, 3, 2, 5};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] get_m(input int k);
        case (k)
            0: return {8'h00, m_d1};
            1: return {8'h00, m_d2};
            2: return {8'h00, m_d4};
            3: return {8'h00, m_d8};
            default: return m_w;
        endcase
    endfunction

    // Schoolbook negacyclic product c2*r2, plus c1, then threshold decode.
    function automatic logic [15:0] ref_m(input int n, input int lq, input logic [15:0] r,
                                          input logic [191:0] a1, input logic [191:0] a2);
        int q;
        int acc[16];
        int cj;
        int v;
        logic [191:0] t;
        logic [15:0] res;
        q = 1 << lq;
        res = '0;
        for (int i = 0; i < 16; i++) acc[i] = 0;
        for (int i = 0; i < n; i++) begin
            if (r[i]) begin
                for (int j = 0; j < n; j++) begin
                    t  = a2 >> (j * lq);
                    cj = int'(t[11:0]) & (q - 1);
                    if (i + j < n) acc[i+j] += cj;
                    else           acc[i+j-n] -= cj;
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            t = a1 >> (i * lq);
            v = acc[i] + (int'(t[11:0]) & (q - 1));
            v = ((v % q) + q) % q;
            res[i] = (v >= q / 4) && (v < 3 * q / 4);
        end
        return res;
    endfunction

    task automatic start0();
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
    endtask

    task automatic wait0(input logic [7:0] exp, input string tag);
        int lat;
        lat = 0;
        while (!valid[0] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'd9);
        chk({tag, " m"}, 64'(m_d1), 64'(exp));
    endtask

    task automatic ack0();
        ack[0] = 1'b1;
        @(posedge clk); #1;
        ack[0] = 1'b0;
        chk("ready after ack", 64'(ready[0]), 64'd1);
    endtask

    initial begin
        int vcount;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b0;
        start = '0;
        ack   = '0;
        r2a = '0; c1a = '0; c2a = '0;
        r2b = '0; c1b = '0; c2b = '0;

        tv[0] = '{8'h00, {8{8'h80}}, {$urandom, $urandom}, 8'hFF};
        tv[1] = '{8'h00, {8{8'h3F}}, {$urandom, $urandom}, 8'h00};
        tv[2] = '{8'h01, 64'h0, 64'h0000_0000_0000_0040, 8'h01};
        tv[3] = '{8'h01, 64'h0, 64'h0000_0000_0000_00C0, 8'h00};
        tv[4] = '{8'h80, 64'h0, 64'h0000_0000_0000_6000, 8'h01};
        tv[5] = '{8'h00, 64'hFF7F_8000_C0BF_403F, 64'h0, 8'h66};

        // reset values
        #12;
        chk("reset ready", 64'(ready), 64'h1F);
        chk("reset valid", 64'(valid), 64'h00);
        chk("reset m", 64'(m_d1), 64'h00);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // table-driven directed vectors on N=8 D=1
        for (int i = 0; i < 6; i++) begin
            r2a = tv[i].r2;
            c1a = tv[i].c1;
            c2a = tv[i].c2;
            start0();
            chk($sformatf("vec%0d ready low", i), 64'(ready[0]), 64'd0);
            wait0(tv[i].exp_m, $sformatf("vec%0d", i));
            ack0();
        end

        // reset abort during MUL cycle 3
        r2a = 8'h00; c1a = {8{8'h80}}; c2a = '0;
        start0();
        repeat (3) begin @(posedge clk); #1; end
        #1 rst = 1'b0;
        #1;
        chk("abort ready", 64'(ready[0]), 64'd1);
        chk("abort valid", 64'(valid[0]), 64'd0);
        chk("abort m", 64'(m_d1), 64'd0);
        #2 rst = 1'b1;
        vcount = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (valid[0]) vcount++;
        end
        chk("abort no valid", 64'(vcount), 64'd0);
        start0();
        wait0(8'hFF, "after abort");
        ack0();

        // handshake: hold ack low, ignored start, release, immediate restart
        r2a = 8'h00; c1a = {8{8'h80}};
        start0();
        wait0(8'hFF, "hs");
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hs hold valid %0d", c), 64'(valid[0]), 64'd1);
            chk($sformatf("hs hold m %0d", c), 64'(m_d1), 64'hFF);
            if (c == 2) begin
                c1a = {8{8'h3F}};
                start[0] = 1'b1;
            end else begin
                start[0] = 1'b0;
            end
            @(posedge clk); #1;
        end
        start[0] = 1'b0;
        ack[0] = 1'b1;
        @(posedge clk); #1;
        ack[0] = 1'b0;
        chk("hs valid cleared", 64'(valid[0]), 64'd0);
        chk("hs ready back", 64'(ready[0]), 64'd1);
        chk("hs m held", 64'(m_d1), 64'hFF);
        start0();
        chk("hs restart accepted", 64'(ready[0]), 64'd0);
        wait0(8'h00, "hs restart");
        ack0();

        // random stimulus on all D variants in parallel, ack held high throughout
        for (int it = 0; it < 8; it++) begin
            r2a = 8'($urandom);
            c1a = {$urandom, $urandom};
            c2a = {$urandom, $urandom};
            r2b = 16'($urandom);
            c1b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            c2b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (it == 0) r2b = 16'hFFFF;
            for (int k = 0; k < 4; k++) exp_arr[k] = ref_m(8, 8, {8'h00, r2a}, {128'h0, c1a}, {128'h0, c2a});
            exp_arr[4] = ref_m(16, 12, r2b, c1b, c2b);
            for (int k = 0; k < 5; k++) begin
                lat_arr[k] = -1;
                nv_arr[k]  = 0;
                got_arr[k] = '0;
            end
            ack   = '1;
            start = '1;
            @(posedge clk); #1;
            start = '0;
            for (int cyc = 1; cyc <= 30; cyc++) begin
                @(posedge clk); #1;
                for (int k = 0; k < 5; k++) begin
                    if (valid[k]) begin
                        nv_arr[k]++;
                        if (lat_arr[k] < 0) begin
                            lat_arr[k] = cyc;
                            got_arr[k] = get_m(k);
                        end
                    end
                end
            end
            ack = '0;
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("rand%0d inst%0d latency", it, k), 64'(lat_arr[k]), 64'(exp_lat[k]));
                chk($sformatf("rand%0d inst%0d m", it, k), 64'(got_arr[k]), 64'(exp_arr[k]));
                chk($sformatf("rand%0d inst%0d valid cycles", it, k), 64'(nv_arr[k]), 64'd1);
            end
            chk($sformatf("rand%0d all ready", it), 64'(ready), 64'h1F);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
